serial_comparator: RTL
======================

# serial_comparator

Sequential, bit-serial magnitude comparator for WIDTH-bit unsigned operands. Operands arrive one bit pair per accepted cycle, in either bit order, and each comparison is framed by a start/done handshake. It produces the same greater/equal/lower result triple (Y1/Y2/Y3) as the lab's combinational comparator. It sits downstream of serial data sources such as shift registers or UART-style links, where parallel operands are not available.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 1 to 32.
- MSB_FIRST, 1: 1 means bits arrive MSB first; 0 means LSB first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a new comparison; sampled only in IDLE.
- bit_valid  input  1  the current A/B bit pair is valid.
- A  input  1  serial bit of operand A.
- B  input  1  serial bit of operand B.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse when the result is valid.
- Y1  output  1  A > B (registered, held).
- Y2  output  1  A == B (registered, held).
- Y3  output  1  A < B (registered, held).

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: busy=0. If start=1, clear the bit counter, set the internal decision to EQ, clear the decided flag, and go to SHIFT.
  - SHIFT: busy=1. Each cycle with bit_valid=1 consumes one A/B pair and increments the counter. Cycles with bit_valid=0 leave all state unchanged (gaps are allowed and unbounded).
  - When the WIDTH-th pair is accepted, go to DONE.
  - DONE: load the decision into Y1/Y2/Y3, assert done for one cycle, then return to IDLE.
- Decision update rule for an accepted pair:
  - MSB_FIRST=1: the first pair with A!=B fixes the decision (A=1,B=0 gives GT; A=0,B=1 gives LT) and sets the decided flag. Later pairs are ignored for the decision but still counted.
  - MSB_FIRST=0: every pair with A!=B overwrites the decision, because a later bit is more significant. Pairs with A==B leave the decision unchanged.
- Exactly one of Y1/Y2/Y3 is high after the first done. All three are 0 only between reset and the first done.
- Outputs Y1/Y2/Y3 hold their value until the next DONE. They do not change during SHIFT.
- Bit counter width is clog2(WIDTH+1). The counter never wraps, because the FSM leaves SHIFT at count WIDTH.

## Timing
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, Y1=0, Y2=0, Y3=0, counter=0, decision=EQ, decided=0. Takes effect immediately, independent of clk.
- Reset deasserted mid-comparison: the block sits in IDLE. The partial operand is discarded and no done is produced.
- Start cycle: no bit is captured in the start cycle itself, even if bit_valid=1. The first pair is accepted on the cycle after start.
- start asserted in SHIFT or DONE: ignored, with no effect on the current comparison.
- Latency: done=1 and the new Y values appear in the cycle after the rising edge that accepts the WIDTH-th pair. With no gaps, done is high in cycle WIDTH+1 counted from the start cycle (cycle 0).
- busy rises the cycle after start and falls the cycle after done.
- The earliest next start is sampled in the cycle after done, so back-to-back comparisons are WIDTH+2 cycles apart.
- done is never high for two consecutive cycles.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-SHIFT -> busy=0, done=0, Y1/Y2/Y3=000 immediately. After release, a start/4 bits sequence completes normally.
- WIDTH=4, MSB_FIRST=1, no gaps:
  - A=1010, B=1001 -> done in cycle 5, Y1=1, Y2=0, Y3=0.
  - Then A=0110, B=0110 -> Y2=1.
- WIDTH=4, MSB_FIRST=0: A=3 (bits sent 1,1,0,0), B=5 (bits sent 1,0,1,0) -> Y3=1. This checks that the more-significant later bit overrides the earlier GT.
- Gapped input: same operands as the first MSB-first case, with bit_valid low for 3 cycles between each bit -> same result (Y1=1). done is delayed by exactly 9 cycles. Y1/Y2/Y3 hold the previous result through SHIFT.
- Protocol abuse:
  - start pulses during SHIFT and DONE -> ignored; result and done timing unchanged.
  - bit_valid=1 in the start cycle -> that pair is not counted.
- Boundary: WIDTH=1 with A=1, B=0 -> Y1=1, done in cycle 2. Back-to-back starts in the cycle after done yield correct consecutive results.

Source files
------------

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator with start/done framing.
// Accepts one A/B bit pair per valid cycle, MSB- or LSB-first, and holds the GT/EQ/LT result.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; result outputs hold the last compare
//   S_SHIFT | consuming bit pairs on bit_valid, counting to WIDTH
//   S_DONE  | one-cycle done pulse, result already loaded
module serial_comparator #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic A,
    input  logic B,
    output logic busy,
    output logic done,
    output logic Y1,
    output logic Y2,
    output logic Y3
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        D_EQ = 2'd0,
        D_GT = 2'd1,
        D_LT = 2'd2
    } dec_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dec_t          dec_q, dec_d;
    logic          decided_q, decided_d;
    logic [2:0]    y_q, y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dec_q     <= D_EQ;
            decided_q <= 1'b0;
            y_q       <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dec_q     <= dec_d;
            decided_q <= decided_d;
            y_q       <= y_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dec_d     = dec_q;
        decided_d = decided_q;
        y_d       = y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = '0;
                    dec_d     = D_EQ;
                    decided_d = 1'b0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    // LSB-first: every later differing bit outranks the earlier ones.
                    if ((A != B) && (!MSB_FIRST || !decided_q)) begin
                        dec_d     = A ? D_GT : D_LT;
                        decided_d = 1'b1;
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_DONE;
                        case (dec_d)
                            D_GT:    y_d = 3'b100;
                            D_LT:    y_d = 3'b001;
                            default: y_d = 3'b010;
                        endcase
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign Y1   = y_q[2];
    assign Y2   = y_q[1];
    assign Y3   = y_q[0];

endmodule
